// File: rtl/rvfi_bus_dmem_monitor.sv
// Passive data-memory bus observer: pairs accepted requests with in-order
// responses and emits one registered RVFI bus record per completed transfer.
module rvfi_bus_dmem_monitor #(
    parameter int XLEN   = 32,
    parameter int BUSLEN = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       mem_valid,
    input  logic                       mem_ready,
    input  logic [XLEN-1:0]            mem_addr,
    input  logic [BUSLEN/8-1:0]        mem_rmask,
    input  logic [BUSLEN/8-1:0]        mem_wmask,
    input  logic [BUSLEN-1:0]          mem_wdata,
    input  logic                       mem_rsp_valid,
    input  logic [BUSLEN-1:0]          mem_rsp_rdata,
    input  logic                       mem_rsp_fault,
    output logic                       rvfi_bus_valid,
    output logic                       rvfi_bus_insn,
    output logic                       rvfi_bus_data,
    output logic                       rvfi_bus_fault,
    output logic [XLEN-1:0]            rvfi_bus_addr,
    output logic [BUSLEN/8-1:0]        rvfi_bus_rmask,
    output logic [BUSLEN-1:0]          rvfi_bus_rdata,
    output logic [BUSLEN/8-1:0]        rvfi_bus_wmask,
    output logic [BUSLEN-1:0]          rvfi_bus_wdata,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       proto_err
);
    localparam int MW = BUSLEN / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Request FIFO storage; contents are don't-care once popped or reset.
    logic [XLEN-1:0]   fifo_addr_q  [DEPTH];
    logic [MW-1:0]     fifo_rmask_q [DEPTH];
    logic [MW-1:0]     fifo_wmask_q [DEPTH];
    logic [BUSLEN-1:0] fifo_wdata_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          err_q;

    logic              rec_valid_q, rec_fault_q;
    logic [XLEN-1:0]   rec_addr_q;
    logic [MW-1:0]     rec_rmask_q, rec_wmask_q;
    logic [BUSLEN-1:0] rec_rdata_q, rec_wdata_q;

    logic              accept, has_mask, empty, full, push, pop, viol;
    logic [BUSLEN-1:0] rdata_masked;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign accept   = mem_valid && mem_ready;
    assign has_mask = |(mem_rmask | mem_wmask);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    // A response never matches a request accepted in the same cycle.
    assign pop      = mem_rsp_valid && !empty;
    assign push     = accept && has_mask && (!full || pop);
    assign viol     = (accept && !has_mask)
                    || (accept && has_mask && full && !pop)
                    || (mem_rsp_valid && empty);

    always_comb begin
        rdata_masked = '0;
        for (int i = 0; i < MW; i++)
            if (fifo_rmask_q[rd_ptr_q][i])
                rdata_masked[8*i +: 8] = mem_rsp_rdata[8*i +: 8];
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= mem_addr;
            fifo_rmask_q[wr_ptr_q] <= mem_rmask;
            fifo_wmask_q[wr_ptr_q] <= mem_wmask;
            fifo_wdata_q[wr_ptr_q] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            rec_valid_q <= 1'b0;
            rec_fault_q <= 1'b0;
            rec_addr_q  <= '0;
            rec_rmask_q <= '0;
            rec_wmask_q <= '0;
            rec_rdata_q <= '0;
            rec_wdata_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q     <= count_d;
            err_q       <= err_q | viol;
            rec_valid_q <= pop;
            rec_fault_q <= pop & mem_rsp_fault;
            rec_addr_q  <= pop ? fifo_addr_q[rd_ptr_q]  : '0;
            rec_rmask_q <= pop ? fifo_rmask_q[rd_ptr_q] : '0;
            rec_wmask_q <= pop ? fifo_wmask_q[rd_ptr_q] : '0;
            rec_wdata_q <= pop ? fifo_wdata_q[rd_ptr_q] : '0;
            rec_rdata_q <= pop ? rdata_masked           : '0;
        end
    end

    assign rvfi_bus_valid = rec_valid_q;
    assign rvfi_bus_insn  = 1'b0;
    assign rvfi_bus_data  = rec_valid_q;
    assign rvfi_bus_fault = rec_fault_q;
    assign rvfi_bus_addr  = rec_addr_q;
    assign rvfi_bus_rmask = rec_rmask_q;
    assign rvfi_bus_rdata = rec_rdata_q;
    assign rvfi_bus_wmask = rec_wmask_q;
    assign rvfi_bus_wdata = rec_wdata_q;
    assign outstanding    = count_q;
    assign proto_err      = err_q;

endmodule

// File: tb/tb_rvfi_bus_dmem_monitor.sv
// Scoreboard bench for rvfi_bus_dmem_monitor: a request-queue model predicts
// each record when its response is driven; a monitor pops and compares.
module tb_rvfi_bus_dmem_monitor;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0, mem_ready = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_rmask = '0, mem_wmask = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        mem_rsp_fault = 1'b0;
    logic        rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault;
    logic [31:0] rvfi_bus_addr, rvfi_bus_rdata, rvfi_bus_wdata;
    logic [3:0]  rvfi_bus_rmask, rvfi_bus_wmask;
    logic [2:0]  outstanding;
    logic        proto_err;

    rvfi_bus_dmem_monitor #(.XLEN(32), .BUSLEN(32), .DEPTH(4)) dut (
        .clock(clock), .resetn(resetn),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .mem_rsp_fault(mem_rsp_fault),
        .rvfi_bus_valid(rvfi_bus_valid), .rvfi_bus_insn(rvfi_bus_insn),
        .rvfi_bus_data(rvfi_bus_data), .rvfi_bus_fault(rvfi_bus_fault),
        .rvfi_bus_addr(rvfi_bus_addr), .rvfi_bus_rmask(rvfi_bus_rmask),
        .rvfi_bus_rdata(rvfi_bus_rdata), .rvfi_bus_wmask(rvfi_bus_wmask),
        .rvfi_bus_wdata(rvfi_bus_wdata), .outstanding(outstanding),
        .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rm, wm;
        logic [31:0] wd;
    } req_t;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rm, wm;
        logic [31:0] wd, rd;
        logic        flt;
    } rec_t;

    req_t mq[$];
    rec_t eq[$];
    int   n_chk = 0, n_pass = 0;
    bit   exp_err = 0, rsp_match = 0, pulse_exp = 0;

    // Monitor: a record pulse is due exactly one cycle after a matched response.
    always begin
        rec_t e;
        @(posedge clock);
        pulse_exp = rsp_match && resetn;
        @(negedge clock);
        if (!resetn) begin
            n_chk++;
            if ({rvfi_bus_valid, rvfi_bus_fault, rvfi_bus_addr, rvfi_bus_rmask, rvfi_bus_wmask,
                 rvfi_bus_rdata, rvfi_bus_wdata, outstanding, proto_err} !== '0)
                $display("FAIL in_reset: outputs not all zero (valid=%b outst=%0d err=%b)",
                         rvfi_bus_valid, outstanding, proto_err);
            else n_pass++;
        end else begin
            n_chk++;
            if (rvfi_bus_valid !== pulse_exp || rvfi_bus_data !== rvfi_bus_valid || rvfi_bus_insn !== 1'b0)
                $display("FAIL pulse_timing: valid=%b data=%b insn=%b expected valid=%b",
                         rvfi_bus_valid, rvfi_bus_data, rvfi_bus_insn, pulse_exp);
            else n_pass++;
            n_chk++;
            if (rvfi_bus_valid === 1'b1) begin
                if (eq.size() == 0) begin
                    $display("FAIL record_unexpected: addr=%h with empty scoreboard", rvfi_bus_addr);
                end else begin
                    e = eq.pop_front();
                    if (rvfi_bus_addr !== e.addr || rvfi_bus_rmask !== e.rm || rvfi_bus_wmask !== e.wm ||
                        rvfi_bus_wdata !== e.wd || rvfi_bus_rdata !== e.rd || rvfi_bus_fault !== e.flt)
                        $display("FAIL record: got a=%h rm=%h wm=%h wd=%h rd=%h f=%b want a=%h rm=%h wm=%h wd=%h rd=%h f=%b",
                                 rvfi_bus_addr, rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_wdata, rvfi_bus_rdata,
                                 rvfi_bus_fault, e.addr, e.rm, e.wm, e.wd, e.rd, e.flt);
                    else n_pass++;
                end
            end else begin
                if ({rvfi_bus_fault, rvfi_bus_addr, rvfi_bus_rmask, rvfi_bus_wmask,
                     rvfi_bus_rdata, rvfi_bus_wdata} !== '0)
                    $display("FAIL idle_payload: nonzero payload a=%h rd=%h f=%b while not valid",
                             rvfi_bus_addr, rvfi_bus_rdata, rvfi_bus_fault);
                else n_pass++;
            end
        end
    end

    // One bus cycle: optional request and optional response; the model pops
    // before it pushes, so a response never matches a same-cycle request.
    task automatic drive(input bit req, input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, input bit rsp, input logic [31:0] rd, input bit flt);
        req_t h;
        rec_t r;
        mem_valid = req; mem_ready = req; mem_addr = a; mem_rmask = rm; mem_wmask = wm; mem_wdata = wd;
        mem_rsp_valid = rsp; mem_rsp_rdata = rd; mem_rsp_fault = flt;
        rsp_match = 0;
        if (rsp) begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                r.addr = h.addr; r.rm = h.rm; r.wm = h.wm; r.wd = h.wd; r.flt = flt;
                r.rd = '0;
                for (int b = 0; b < 4; b++) if (h.rm[b]) r.rd[8*b +: 8] = rd[8*b +: 8];
                eq.push_back(r);
                rsp_match = 1;
            end else exp_err = 1;
        end
        if (req) begin
            if ((rm | wm) == 4'h0) exp_err = 1;
            else if (mq.size() < 4) begin
                h.addr = a; h.rm = rm; h.wm = wm; h.wd = wd;
                mq.push_back(h);
            end else exp_err = 1;
        end
        @(posedge clock); #1;
        mem_valid = 0; mem_ready = 0; mem_rsp_valid = 0; rsp_match = 0;
    endtask

    task automatic req_only(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd);
        drive(1, a, rm, wm, wd, 0, '0, 0);
    endtask
    task automatic rsp_only(input logic [31:0] rd, input bit flt);
        drive(0, '0, '0, '0, '0, 1, rd, flt);
    endtask
    task automatic idle();
        drive(0, '0, '0, '0, '0, 0, '0, 0);
    endtask
    task automatic do_reset();
        resetn = 0; mq.delete(); eq.delete(); exp_err = 0; rsp_match = 0;
        repeat (2) @(posedge clock);
        #1 resetn = 1;
    endtask

    task automatic test_reset();
        #3;
        n_chk++;
        if (rvfi_bus_valid !== 0 || outstanding !== 0 || proto_err !== 0 || rvfi_bus_addr !== 0)
            $display("FAIL reset_state: valid=%b outst=%0d err=%b", rvfi_bus_valid, outstanding, proto_err);
        else n_pass++;
        @(posedge clock); #1 resetn = 1;
    endtask

    task automatic test_single_read();
        req_only(32'h1000, 4'hF, 4'h0, 32'h0);
        n_chk++;
        if (outstanding !== 3'd1) $display("FAIL single_outst1: got %0d want 1", outstanding); else n_pass++;
        idle(); idle();
        rsp_only(32'hDEADBEEF, 0);
        n_chk++;
        if (rvfi_bus_valid !== 1 || rvfi_bus_addr !== 32'h1000 || rvfi_bus_rdata !== 32'hDEADBEEF ||
            rvfi_bus_wmask !== 4'h0 || rvfi_bus_fault !== 0 || outstanding !== 3'd0)
            $display("FAIL single_read: valid=%b addr=%h rdata=%h wm=%h f=%b outst=%0d want 1 1000 deadbeef 0 0 0",
                     rvfi_bus_valid, rvfi_bus_addr, rvfi_bus_rdata, rvfi_bus_wmask, rvfi_bus_fault, outstanding);
        else n_pass++;
        idle();
    endtask

    task automatic test_masked_read();
        req_only(32'h300, 4'h6, 4'h0, 32'h0);
        rsp_only(32'hAABBCCDD, 0);
        n_chk++;
        if (rvfi_bus_rdata !== 32'h00BBCC00 || rvfi_bus_rmask !== 4'h6)
            $display("FAIL masked_read: rdata=%h rmask=%h want 00bbcc00 6", rvfi_bus_rdata, rvfi_bus_rmask);
        else n_pass++;
        idle();
    endtask

    task automatic test_fault_write();
        req_only(32'h2004, 4'h0, 4'h3, 32'h1234);
        idle();
        rsp_only(32'hFFFFFFFF, 1);
        n_chk++;
        if (rvfi_bus_fault !== 1 || rvfi_bus_wmask !== 4'h3 || rvfi_bus_wdata !== 32'h1234 ||
            rvfi_bus_rmask !== 4'h0 || rvfi_bus_rdata !== 32'h0 || rvfi_bus_addr !== 32'h2004)
            $display("FAIL fault_write: f=%b wm=%h wd=%h rm=%h rd=%h a=%h want 1 3 1234 0 0 2004",
                     rvfi_bus_fault, rvfi_bus_wmask, rvfi_bus_wdata, rvfi_bus_rmask, rvfi_bus_rdata, rvfi_bus_addr);
        else n_pass++;
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) req_only(32'h4 * i, 4'hF, (i == 2) ? 4'hF : 4'h0, 32'h5500 + i);
        n_chk++;
        if (outstanding !== 3'd4) $display("FAIL b2b_peak: got %0d want 4", outstanding); else n_pass++;
        drive(1, 32'h10, 4'hF, 4'h0, 32'h0, 1, 32'h11110000, 0);
        n_chk++;
        if (outstanding !== 3'd4 || proto_err !== 0)
            $display("FAIL b2b_full_pushpop: outst=%0d err=%b want 4 0", outstanding, proto_err);
        else n_pass++;
        for (int i = 1; i < 5; i++) rsp_only(32'h11110000 + i, i == 3);
        n_chk++;
        if (outstanding !== 3'd0 || proto_err !== 0)
            $display("FAIL b2b_drain: outst=%0d err=%b want 0 0", outstanding, proto_err);
        else n_pass++;
        idle();
    endtask

    task automatic test_violations();
        rsp_only(32'h12345678, 0);
        n_chk++;
        if (proto_err !== 1 || rvfi_bus_valid !== 0)
            $display("FAIL viol_empty_rsp: err=%b valid=%b want 1 0", proto_err, rvfi_bus_valid);
        else n_pass++;
        do_reset();
        req_only(32'h40, 4'h0, 4'h0, 32'h0);
        n_chk++;
        if (proto_err !== 1 || outstanding !== 0)
            $display("FAIL viol_zero_mask: err=%b outst=%0d want 1 0", proto_err, outstanding);
        else n_pass++;
        do_reset();
        for (int i = 0; i < 5; i++) req_only(32'h100 + 4 * i, 4'hF, 4'h0, 32'h0);
        n_chk++;
        if (proto_err !== 1 || outstanding !== 3'd4)
            $display("FAIL viol_overflow: err=%b outst=%0d want 1 4", proto_err, outstanding);
        else n_pass++;
        for (int i = 0; i < 4; i++) rsp_only(32'hA0A0A0A0 + i, 0);
        idle();
        do_reset();
        drive(1, 32'h80, 4'hF, 4'h0, 32'h0, 1, 32'h77777777, 0);
        n_chk++;
        if (proto_err !== 1 || outstanding !== 3'd1 || rvfi_bus_valid !== 0)
            $display("FAIL viol_same_cycle: err=%b outst=%0d valid=%b want 1 1 0", proto_err, outstanding, rvfi_bus_valid);
        else n_pass++;
        rsp_only(32'hCAFEF00D, 0);
        n_chk++;
        if (rvfi_bus_addr !== 32'h80 || rvfi_bus_rdata !== 32'hCAFEF00D)
            $display("FAIL viol_same_cycle_match: addr=%h rdata=%h want 80 cafef00d", rvfi_bus_addr, rvfi_bus_rdata);
        else n_pass++;
        idle();
        do_reset();
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) req_only(32'h600 + 4 * i, 4'hF, 4'h0, 32'h0);
        rsp_only(32'h0BADF00D, 0);
        n_chk++;
        if (outstanding !== 3'd2 || rvfi_bus_valid !== 1)
            $display("FAIL midflight_pre: outst=%0d valid=%b want 2 1", outstanding, rvfi_bus_valid);
        else n_pass++;
        resetn = 0; mq.delete(); eq.delete(); exp_err = 0;
        #1;
        n_chk++;
        if (rvfi_bus_valid !== 0 || rvfi_bus_addr !== 0 || rvfi_bus_rdata !== 0 || outstanding !== 0 || proto_err !== 0)
            $display("FAIL midflight_async: valid=%b addr=%h rdata=%h outst=%0d err=%b want all 0",
                     rvfi_bus_valid, rvfi_bus_addr, rvfi_bus_rdata, outstanding, proto_err);
        else n_pass++;
        repeat (2) @(posedge clock);
        #1 resetn = 1;
        rsp_only(32'h99999999, 0);
        n_chk++;
        if (proto_err !== 1 || rvfi_bus_valid !== 0 || proto_err !== exp_err)
            $display("FAIL midflight_post_rsp: err=%b valid=%b want 1 0", proto_err, rvfi_bus_valid);
        else n_pass++;
        idle(); idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_masked_read();
        test_fault_write();
        test_back_to_back();
        n_chk++;
        if (proto_err !== exp_err) $display("FAIL err_clean: got %b want %b", proto_err, exp_err); else n_pass++;
        test_violations();
        test_reset_midflight();
        n_chk++;
        if (eq.size() != 0) $display("FAIL records_missing: %0d expected records never seen", eq.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
